// File: rtl/lsu_pkg.sv
// Shared types for the load/store sequencer: funct3 encodings, FSM states, lane masks.
// The state set grows by REQ2/WAIT2 when LSU_SPLIT_MISALIGNED_EN is defined.
package f3Ld;
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } funct3Load;
endpackage

package f3St;
  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } funct3Store;
endpackage

package lsu_pkg;
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
`ifdef LSU_SPLIT_MISALIGNED_EN
    ,
    REQ2,
    WAIT2
`endif
  } lsuState;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift and byte enables, load extraction and extension.
// Works on a two-word window so one instance serves both halves of a split access.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic            upper,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_lo,
  input  logic [XLEN-1:0] rdata_hi,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [3:0]        base;
  logic [7:0]        mask;
  logic [2*XLEN-1:0] wide;
  logic [XLEN-1:0]   rd_w;
  logic              sgn;

  always_comb begin
    case (funct3[1:0])
      2'd0:    base = BE_B;
      2'd1:    base = BE_H;
      default: base = BE_W;
    endcase
    mask       = {4'b0000, base} << off;
    be         = upper ? mask[7:4] : mask[3:0];
    wide       = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    wdata_lane = upper ? wide[2*XLEN-1:XLEN] : wide[XLEN-1:0];
    rd_w       = XLEN'({rdata_hi, rdata_lo} >> {off, 3'b000});
    sgn        = ~funct3[2];
    case (funct3[1:0])
      2'd0:    rdata_ext = {{(XLEN-8){sgn & rd_w[7]}}, rd_w[7:0]};
      2'd1:    rdata_ext = {{(XLEN-16){sgn & rd_w[15]}}, rd_w[15:0]};
      default: rdata_ext = rd_w;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port; all outputs registered.
// Define LSU_SPLIT_MISALIGNED_EN to split misaligned accesses into two bus transfers.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            rsp_err
);

  lsuState state_q, state_n;

  logic            store_q, store_n;
  logic [2:0]      f3_q, f3_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [XLEN-1:0] wdata_q, wdata_n;
  logic [4:0]      rd_q, rd_n;
  logic [XLEN-1:0] rdata_lo_q, rdata_lo_n;
  logic [XLEN-1:0] rdata_hi_n;
  logic            err_q, err_n;
  logic            accept, illegal, misaligned, in_wait, upper;

`ifdef LSU_SPLIT_MISALIGNED_EN
  logic [XLEN-1:0] rdata_hi_q;
  logic            mis_q, mis_n;
`endif

  logic            req_ready_d, mem_req_d, mem_we_d, rsp_valid_d, rsp_err_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d, rsp_data_d, wdata_lane, rdata_ext;
  logic [3:0]      mem_be_d, be_lane;
  logic [4:0]      rsp_rd_d;

  assign accept = req_valid && req_ready;

  always_comb begin
    illegal = 1'b0;
    if (req_store) begin
      case (f3St::funct3Store'(req_funct3))
        f3St::SB, f3St::SH, f3St::SW: illegal = 1'b0;
        default:                      illegal = 1'b1;
      endcase
    end else begin
      case (f3Ld::funct3Load'(req_funct3))
        f3Ld::LB, f3Ld::LH, f3Ld::LW, f3Ld::LBU, f3Ld::LHU: illegal = 1'b0;
        default:                                            illegal = 1'b1;
      endcase
    end
    misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
  end

  // Next-value view of the latched fields, so registered outputs can be loaded
  // on the same edge the fields (or read data) are captured.
  always_comb begin
    store_n = accept ? req_store  : store_q;
    f3_n    = accept ? req_funct3 : f3_q;
    addr_n  = accept ? req_addr   : addr_q;
    wdata_n = accept ? req_wdata  : wdata_q;
    rd_n    = accept ? req_rd     : rd_q;
`ifdef LSU_SPLIT_MISALIGNED_EN
    in_wait    = (state_q == WAIT) || (state_q == WAIT2);
    mis_n      = accept ? misaligned : mis_q;
    rdata_hi_n = (state_q == WAIT2 && mem_rvalid) ? mem_rdata : rdata_hi_q;
`else
    in_wait    = (state_q == WAIT);
    rdata_hi_n = '0;
`endif
    rdata_lo_n = (state_q == WAIT && mem_rvalid) ? mem_rdata : rdata_lo_q;
    if (accept) begin
`ifdef LSU_SPLIT_MISALIGNED_EN
      err_n = illegal;
`else
      err_n = illegal || misaligned;
`endif
    end else begin
      err_n = err_q || (in_wait && mem_rvalid && mem_err);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (illegal) state_n = RESP;
`ifdef LSU_SPLIT_MISALIGNED_EN
        else         state_n = REQ;
`else
        else if (misaligned) state_n = RESP;
        else                 state_n = REQ;
`endif
      end
      REQ:  if (mem_gnt) state_n = WAIT;
`ifdef LSU_SPLIT_MISALIGNED_EN
      WAIT:  if (mem_rvalid) state_n = mis_q ? REQ2 : RESP;
      REQ2:  if (mem_gnt) state_n = WAIT2;
      WAIT2: if (mem_rvalid) state_n = RESP;
`else
      WAIT: if (mem_rvalid) state_n = RESP;
`endif
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef LSU_SPLIT_MISALIGNED_EN
  assign upper = (state_n == REQ2);
`else
  assign upper = 1'b0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (f3_n),
    .off        (addr_n[1:0]),
    .upper      (upper),
    .wdata      (wdata_n),
    .rdata_lo   (rdata_lo_n),
    .rdata_hi   (rdata_hi_n),
    .be         (be_lane),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  always_comb begin
    req_ready_d = (state_n == IDLE);
`ifdef LSU_SPLIT_MISALIGNED_EN
    mem_req_d   = (state_n == REQ) || (state_n == REQ2);
`else
    mem_req_d   = (state_n == REQ);
`endif
    mem_we_d    = mem_req_d && store_n;
    mem_addr_d  = mem_req_d ? ({addr_n[XLEN-1:2], 2'b00} + XLEN'({upper, 2'b00})) : '0;
    mem_be_d    = mem_req_d ? be_lane : '0;
    mem_wdata_d = mem_req_d ? wdata_lane : '0;
    rsp_valid_d = (state_n == RESP);
    rsp_data_d  = (rsp_valid_d && !store_n && !err_n) ? rdata_ext : '0;
    rsp_rd_d    = rsp_valid_d ? rd_n : '0;
    rsp_err_d   = rsp_valid_d && err_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_lo_q <= '0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      store_q    <= store_n;
      f3_q       <= f3_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rd_q       <= rd_n;
      rdata_lo_q <= rdata_lo_n;
      err_q      <= err_n;
      req_ready  <= req_ready_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_rd     <= rsp_rd_d;
      rsp_err    <= rsp_err_d;
    end
  end

`ifdef LSU_SPLIT_MISALIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_hi_q <= '0;
      mis_q      <= 1'b0;
    end else begin
      rdata_hi_q <= rdata_hi_n;
      mis_q      <= mis_n;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: expected responses queued at request time, checked on rsp_valid.
// Split-access expectations follow LSU_SPLIT_MISALIGNED_EN.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    check_val({tag, ".mem_req"},   32'(mem_req),   32'd0);
    check_val({tag, ".mem_we"},    32'(mem_we),    32'd0);
    check_val({tag, ".mem_addr"},  mem_addr,       32'd0);
    check_val({tag, ".mem_be"},    32'(mem_be),    32'd0);
    check_val({tag, ".mem_wdata"}, mem_wdata,      32'd0);
    check_val({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, ".rsp_data"},  rsp_data,       32'd0);
    check_val({tag, ".rsp_rd"},    32'(rsp_rd),    32'd0);
    check_val({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // Drives one request, services the bus with zero-wait grant and rvalid, checks the
  // bus fields of each access, latency, and the response against the scoreboard.
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int unsigned n_acc,
                        input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                        input logic [31:0] rdata0, input logic err0,
                        input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] rdata1,
                        input int unsigned lat, input logic [31:0] exp_data, input logic exp_err,
                        input int unsigned hold);
    int unsigned cyc;
    int unsigned acc;
    exp_t e;
    @(negedge clk);
    check_val({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    sb.push_back('{data: exp_data, err: exp_err, rd: rd});
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    acc = 0;
    while (!rsp_valid && cyc < 30) begin
      if (mem_req) begin
        check_val($sformatf("%s.we%0d", tag, acc), 32'(mem_we), 32'(st));
        if (acc == 0) begin
          check_val({tag, ".addr0"}, mem_addr, a0);
          check_val({tag, ".be0"}, 32'(mem_be), 32'(be0));
          if (st) check_val({tag, ".wdata0"}, mem_wdata, wd0);
        end else begin
          check_val({tag, ".addr1"}, mem_addr, a1);
          check_val({tag, ".be1"}, 32'(mem_be), 32'(be1));
        end
        mem_gnt = 1'b1;
        @(negedge clk); cyc++;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = (acc == 0) ? rdata0 : rdata1;
        mem_err    = (acc == 0) ? err0 : 1'b0;
        @(negedge clk); cyc++;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = '0;
        acc++;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    e = sb.pop_front();
    if (!rsp_valid) begin
      check_val({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, ".lat"}, cyc, lat);
      check_val({tag, ".naccess"}, acc, n_acc);
      for (int unsigned i = 0; i < hold; i++) begin
        check_val({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
        check_val({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        check_val({tag, ".hold_data"}, rsp_data, e.data);
        check_val({tag, ".hold_err"}, 32'(rsp_err), 32'(e.err));
        @(negedge clk);
      end
      check_val({tag, ".data"}, rsp_data, e.data);
      check_val({tag, ".err"}, 32'(rsp_err), 32'(e.err));
      check_val({tag, ".rd"}, 32'(rsp_rd), 32'(e.rd));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_val({tag, ".valid_drop"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    run_op("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 5'd1, 1, 32'h100, 4'hF, 32'h0,
           32'hDEADBEEF, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);
    run_op("lb103", 1'b0, 3'd0, 32'h103, 32'h0, 5'd2, 1, 32'h100, 4'h8, 32'h0,
           32'h80112233, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0);
    run_op("lbu103", 1'b0, 3'd4, 32'h103, 32'h0, 5'd3, 1, 32'h100, 4'h8, 32'h0,
           32'h80112233, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'h00000080, 1'b0, 0);
    run_op("sh202", 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 5'd4, 1, 32'h200, 4'hC, 32'hABCD0000,
           32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'h0, 1'b0, 5);
    run_op("lh102", 1'b0, 3'd1, 32'h102, 32'h0, 5'd5, 1, 32'h100, 4'hC, 32'h0,
           32'h80017777, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'hFFFF8001, 1'b0, 0);
    run_op("lhu102", 1'b0, 3'd5, 32'h102, 32'h0, 5'd6, 1, 32'h100, 4'hC, 32'h0,
           32'h80017777, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'h00008001, 1'b0, 0);
    run_op("sb101", 1'b1, 3'd0, 32'h101, 32'h123456AB, 5'd7, 1, 32'h100, 4'h2, 32'h3456AB00,
           32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'h0, 1'b0, 0);
`ifdef LSU_SPLIT_MISALIGNED_EN
    run_op("lw101", 1'b0, 3'd2, 32'h101, 32'h0, 5'd8, 2, 32'h100, 4'hE, 32'h0,
           32'h44332211, 1'b0, 32'h104, 4'h1, 32'h88776655, 5, 32'h55443322, 1'b0, 0);
`else
    run_op("lw101", 1'b0, 3'd2, 32'h101, 32'h0, 5'd8, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1'b1, 0);
`endif
    run_op("ld_f3_6", 1'b0, 3'd6, 32'h100, 32'h0, 5'd9, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1'b1, 0);
    run_op("st_f3_3", 1'b1, 3'd3, 32'h100, 32'h0, 5'd10, 0, 32'h0, 4'h0, 32'h0,
           32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1'b1, 0);
    run_op("lw_buserr", 1'b0, 3'd2, 32'h104, 32'h0, 5'd11, 1, 32'h104, 4'hF, 32'h0,
           32'hCAFEF00D, 1'b1, 32'h0, 4'h0, 32'h0, 3, 32'h0, 1'b1, 0);

    // Reset while a load sits in WAIT
    @(negedge clk);
    req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; req_rd = 5'd12;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("rstwait.mem_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rstwait.async");
    @(posedge clk);
    #1;
    check_reset_outputs("rstwait.edge");
    @(negedge clk);
    rst = 1'b0;

    run_op("lw_after_rst", 1'b0, 3'd2, 32'h108, 32'h0, 5'd13, 1, 32'h108, 4'hF, 32'h0,
           32'h01234567, 1'b0, 32'h0, 4'h0, 32'h0, 3, 32'h01234567, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port of the RV32 core. It accepts one LOAD/STORE operation at a time and checks funct3 and alignment. It drives a grant/valid memory bus with word address and byte enables, then returns sign- or zero-extended load data, or a store completion, through a response handshake.

## Interface
- XLEN, 32: data/address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  operation offered by execute
- req_ready  out  1  controller can accept; high only in IDLE
- req_store  in  1  1 = STORE, 0 = LOAD
- req_funct3  in  3  width/sign code
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- req_rd  in  5  load destination register, returned unchanged
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  write access
- mem_addr  out  XLEN  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-shifted write data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data or write ack valid; earliest one cycle after mem_gnt
- mem_rdata  in  XLEN  read word
- mem_err  in  1  bus error, qualified by mem_rvalid
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback consumes result
- rsp_data  out  XLEN  extended load data; 0 for stores
- rsp_rd  out  5  captured req_rd
- rsp_err  out  1  misaligned, illegal funct3 or bus error

## Operation
- States: IDLE, REQ, WAIT, RESP. With the split feature, REQ2 and WAIT2 are added.
- IDLE: on req_valid&&req_ready, latch all request fields. An illegal funct3 is any LOAD value in {3,6,7} or any STORE value in {3..7}; this goes to RESP with rsp_err=1 and no bus access. A misaligned access is a halfword with addr[0]=1, or a word with addr[1:0]!=0. A misaligned access is handled as defined under Configuration. Every other request goes to REQ.
- REQ: mem_req=1 with stable addr, be, we and wdata. On mem_gnt go to WAIT.
- WAIT: on mem_rvalid, capture the data, extend it by funct3 (LB/LH sign-extend, LBU/LHU zero-extend) and go to RESP. mem_err sets rsp_err and forces rsp_data=0.
- RESP: rsp_valid=1 with stable fields. On rsp_ready go to IDLE.
- Byte enables: SB gives 4'b0001<<off, SH gives 4'b0011<<off, SW gives 4'b1111. Write data is shifted left by 8*off.
- mem_rvalid outside WAIT/WAIT2 is ignored. mem_gnt outside REQ/REQ2 is ignored.
- Reset at any point returns to IDLE and drops any in-flight access; the bus must tolerate an abandoned request.
- Reset values: req_ready=1; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_err=0.

## Timing
- All outputs come straight from registers; there is no combinational path from an input to an output.
- Fastest aligned access:
  - cycle 0: accept
  - cycle 1: mem_req (granted)
  - cycle 2: mem_rvalid
  - cycle 3: rsp_valid
- Error without bus access: accept in cycle 0, rsp_valid in cycle 1.
- Throughput is one operation per 4 cycles at best. req_ready returns the cycle after rsp_valid&&rsp_ready.
- An access with mem_gnt and mem_rvalid arriving in the same cycle is illegal bus behaviour and is not supported.

## Configuration
- LSU_SPLIT_MISALIGNED_EN, when defined:
  - A misaligned access is split into two bus accesses.
  - The first access targets word addr&~3 with the upper lanes.
  - The second access targets (addr&~3)+4 with the remaining lower lanes, through REQ2/WAIT2.
  - Load bytes are merged before extension. rsp_err is the OR of both mem_err values.
  - The second access is issued even if the first errs.
- When undefined: a misaligned access gives rsp_err=1 one cycle after accept, with no bus access. REQ2/WAIT2 do not exist.

## Structure
- Package lsu_pkg holds:
  - the state enum lsuState
  - the lane-mask constants BE_B, BE_H, BE_W
- funct3 decoding uses the existing f3Ld::funct3Load and f3St::funct3Store enums.
- Sub-module lsu_align is purely combinational. It performs store lane shift and byte-enable generation, and load lane extraction and extension. It is used by lsu_ctrl for both halves of a split access.

## Test plan
- LW at 0x100: mem_rdata=0xDEADBEEF, grant in cycle 1 → mem_addr=0x100, mem_be=4'hF, rsp_data=0xDEADBEEF in cycle 3.
- LB at 0x103: rdata=0x80112233 → be=4'h8, rsp_data=0xFFFFFF80. Same access as LBU → rsp_data=0x00000080.
- SH at 0x202 with wdata=0x0000ABCD → mem_we=1, mem_addr=0x200, mem_be=4'hC, mem_wdata=0xABCD0000, rsp_data=0.
- LW at 0x101:
  - feature off → rsp_err=1 in cycle 1 and mem_req never asserted.
  - feature on → two accesses, 0x100 with be=4'hE then 0x104 with be=4'h1. With rdata 0x44332211 then 0x88776655, rsp_data=0x55443322.
- Load funct3=3'b110 → rsp_err=1 and no mem_req. Also check mem_err on rvalid → rsp_err=1 and rsp_data=0.
- Hold rsp_ready=0 for 5 cycles → rsp fields stable and req_ready=0. Assert rst during WAIT → all outputs at reset values on the next edge.
